dxt_mem_arbiter: RTL and testbench

- Shares one single-port DAT or DCT table RAM between two requesters: the controller/recovery FSM (hw port) and the CSR register-interface path (sw port).
- Sits between the i3c core's table-access logic and the exported memory sink/source structs that drive the 1-port RAM macro.
- Arbitration is fixed-priority with an anti-starvation override and a hw lock for atomic read-modify-write.
- Read data is routed back to the granted requester one cycle after grant.

---
 rtl/dxt_mem_arbiter_pkg.sv | 55 +++++
 rtl/dxt_mem_arbiter_if.sv | 54 +++++
 rtl/dxt_mem_arbiter.sv | 103 ++++++++++
 tb/tb_dxt_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dxt_mem_arbiter_pkg.sv
// Shared types and constants for the DAT/DCT table RAM arbiter.
// Table geometry lives here so both table instances and their requesters agree.
package dxt_mem_arbiter_pkg;

  localparam int unsigned DatAw          = 5;
  localparam int unsigned DctAw          = 5;
  localparam int unsigned DatDw          = 64;
  localparam int unsigned DctDw          = 128;
  localparam int unsigned DxtStarveLimit = 4;
  localparam int unsigned StarveW        = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } dxt_arb_state_e;

  typedef enum logic [0:0] {
    OwnerHw = 1'b0,
    OwnerSw = 1'b1
  } dxt_owner_e;

  typedef struct packed {
    logic             req;
    logic             write;
    logic [DatAw-1:0] addr;
    logic [DatDw-1:0] wdata;
    logic [DatDw-1:0] wmask;
  } dxt_dat_req_t;

  typedef struct packed {
    logic             req;
    logic             write;
    logic [DctAw-1:0] addr;
    logic [DctDw-1:0] wdata;
    logic [DctDw-1:0] wmask;
  } dxt_dct_req_t;

  // Waiting-cycle counter step: clears when not waiting, saturates at the limit.
  function automatic logic [StarveW-1:0] starve_next(
    input logic [StarveW-1:0] cur,
    input logic [StarveW-1:0] limit,
    input logic               waiting
  );
    logic [StarveW-1:0] nxt;
    if (!waiting) begin
      nxt = {StarveW{1'b0}};
    end else if (cur >= limit) begin
      nxt = limit;
    end else begin
      nxt = cur + {{(StarveW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dxt_mem_arbiter_if.sv
// Requester (hw/sw) and RAM-side signal bundle of the table arbiter.
// slave is the arbiter's view; master is the requesters' plus RAM's view.
interface dxt_mem_arbiter_if
  import dxt_mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = DatAw,
  parameter int unsigned DataWidth = 64
) ();

  logic                 hw_req_i;
  logic                 hw_lock_i;
  logic                 hw_write_i;
  logic [AddrWidth-1:0] hw_addr_i;
  logic [DataWidth-1:0] hw_wdata_i;
  logic [DataWidth-1:0] hw_wmask_i;
  logic                 hw_gnt_o;
  logic                 hw_rvalid_o;
  logic [DataWidth-1:0] hw_rdata_o;

  logic                 sw_req_i;
  logic                 sw_write_i;
  logic [AddrWidth-1:0] sw_addr_i;
  logic [DataWidth-1:0] sw_wdata_i;
  logic [DataWidth-1:0] sw_wmask_i;
  logic                 sw_gnt_o;
  logic                 sw_rvalid_o;
  logic [DataWidth-1:0] sw_rdata_o;

  logic                 mem_req_o;
  logic                 mem_write_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [DataWidth-1:0] mem_wmask_o;
  logic [DataWidth-1:0] mem_rdata_i;

  modport slave (
    input  hw_req_i, hw_lock_i, hw_write_i, hw_addr_i, hw_wdata_i, hw_wmask_i,
    output hw_gnt_o, hw_rvalid_o, hw_rdata_o,
    input  sw_req_i, sw_write_i, sw_addr_i, sw_wdata_i, sw_wmask_i,
    output sw_gnt_o, sw_rvalid_o, sw_rdata_o,
    output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i
  );

  modport master (
    output hw_req_i, hw_lock_i, hw_write_i, hw_addr_i, hw_wdata_i, hw_wmask_i,
    input  hw_gnt_o, hw_rvalid_o, hw_rdata_o,
    output sw_req_i, sw_write_i, sw_addr_i, sw_wdata_i, sw_wmask_i,
    input  sw_gnt_o, sw_rvalid_o, sw_rdata_o,
    input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dxt_mem_arbiter.sv
// Single-port DAT/DCT table RAM arbiter: hw-priority with sw anti-starvation,
// hw lock for atomic read-modify-write, 1-cycle read data return to the owner.
module dxt_mem_arbiter
  import dxt_mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth   = DatAw,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned StarveLimit = DxtStarveLimit
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dxt_mem_arbiter_if.slave    bus,
  output logic                locked_o
);

  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  dxt_arb_state_e     state_r, state_next_s;
  logic [StarveW-1:0] starve_r;
  logic               rd_pend_r;
  dxt_owner_e         rd_owner_r;
  logic               hw_gnt_s, sw_gnt_s, lock_hold_s;

  // Grant selection and next state; a lock dropping this cycle already arbitrates as ARB.
  always_comb begin
    state_next_s = state_r;
    hw_gnt_s     = 1'b0;
    sw_gnt_s     = 1'b0;
    lock_hold_s  = 1'b0;
    if (!rst_ni) begin
      state_next_s = ARB;
    end else begin
      lock_hold_s = (state_r == LOCKED) && bus.hw_lock_i;
      if (lock_hold_s) begin
        hw_gnt_s = bus.hw_req_i;
      end else if (bus.hw_req_i && bus.sw_req_i) begin
        if (starve_r == StarveMax) begin
          sw_gnt_s = 1'b1;
        end else begin
          hw_gnt_s = 1'b1;
        end
      end else begin
        hw_gnt_s = bus.hw_req_i;
        sw_gnt_s = bus.sw_req_i;
      end
      case (state_r)
        ARB:     state_next_s = (hw_gnt_s && bus.hw_lock_i) ? LOCKED : ARB;
        LOCKED:  state_next_s = bus.hw_lock_i ? LOCKED : ARB;
        default: state_next_s = ARB;
      endcase
    end
  end

  // State, starvation counter and pending-read bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ARB;
      starve_r   <= {StarveW{1'b0}};
      rd_pend_r  <= 1'b0;
      rd_owner_r <= OwnerHw;
    end else begin
      state_r    <= state_next_s;
      starve_r   <= starve_next(starve_r, StarveMax, bus.sw_req_i && !sw_gnt_s);
      rd_pend_r  <= (hw_gnt_s && !bus.hw_write_i) || (sw_gnt_s && !bus.sw_write_i);
      rd_owner_r <= sw_gnt_s ? OwnerSw : OwnerHw;
    end
  end

  // RAM port mirrors whichever requester holds the grant; idle drives zeros.
  always_comb begin
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = {AddrWidth{1'b0}};
    bus.mem_wdata_o = {DataWidth{1'b0}};
    bus.mem_wmask_o = {DataWidth{1'b0}};
    if (hw_gnt_s) begin
      bus.mem_write_o = bus.hw_write_i;
      bus.mem_addr_o  = bus.hw_addr_i;
      bus.mem_wdata_o = bus.hw_wdata_i;
      bus.mem_wmask_o = bus.hw_wmask_i;
    end else if (sw_gnt_s) begin
      bus.mem_write_o = bus.sw_write_i;
      bus.mem_addr_o  = bus.sw_addr_i;
      bus.mem_wdata_o = bus.sw_wdata_i;
      bus.mem_wmask_o = bus.sw_wmask_i;
    end else begin
      bus.mem_write_o = 1'b0;
    end
  end

  // Read return: rvalid is qualified by reset so a read in flight at reset is dropped.
  always_comb begin
    bus.hw_rvalid_o = rst_ni && rd_pend_r && (rd_owner_r == OwnerHw);
    bus.sw_rvalid_o = rst_ni && rd_pend_r && (rd_owner_r == OwnerSw);
    bus.hw_rdata_o  = bus.hw_rvalid_o ? bus.mem_rdata_i : {DataWidth{1'b0}};
    bus.sw_rdata_o  = bus.sw_rvalid_o ? bus.mem_rdata_i : {DataWidth{1'b0}};
  end

  assign bus.hw_gnt_o  = hw_gnt_s;
  assign bus.sw_gnt_o  = sw_gnt_s;
  assign bus.mem_req_o = hw_gnt_s || sw_gnt_s;
  assign locked_o      = rst_ni && (state_r == LOCKED);

endmodule

// File: tb/tb_dxt_mem_arbiter.sv
// Self-checking bench for dxt_mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model (waiting count, lock flag, shadow RAM).
module tb_dxt_mem_arbiter;
  import dxt_mem_arbiter_pkg::*;

  localparam int AW  = DatAw;
  localparam int DW  = 64;
  localparam int LIM = DxtStarveLimit;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_ni;
  logic locked;
  always #5 clk = ~clk;

  dxt_mem_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  dxt_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .StarveLimit(LIM)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .bus     (bus),
    .locked_o(locked)
  );

  // RAM behaviour: masked write, 1-cycle read latency, contents preloaded in reset
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram[1] <= 64'h1111_2222_3333_4444;
      ram[3] <= 64'h3333_CCCC_0000_FFFF;
      ram[5] <= 64'h0123_4567_89AB_CDEF;
    end else if (bus.mem_req_o) begin
      if (bus.mem_write_o)
        ram[bus.mem_addr_o] <= (ram[bus.mem_addr_o] & ~bus.mem_wmask_o) |
                               (bus.mem_wdata_o & bus.mem_wmask_o);
      else
        bus.mem_rdata_i <= ram[bus.mem_addr_o];
    end
  end

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [DW-1:0] shadow [DEPTH];
  int            m_wait;
  bit            m_locked;
  bit            m_pend;
  bit            m_owner_sw;
  logic [DW-1:0] m_exp;

  // last observed values for scenario-specific checks
  logic o_hw_gnt, o_sw_gnt, o_hw_rv, o_sw_rv;
  logic [DW-1:0] o_hw_rd, o_sw_rd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload_shadow();
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    shadow[1] = 64'h1111_2222_3333_4444;
    shadow[3] = 64'h3333_CCCC_0000_FFFF;
    shadow[5] = 64'h0123_4567_89AB_CDEF;
  endtask

  task automatic set_hw(input bit req, input bit lock, input bit wr, input int addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    bus.hw_req_i = req; bus.hw_lock_i = lock; bus.hw_write_i = wr;
    bus.hw_addr_i = AW'(addr); bus.hw_wdata_i = wd; bus.hw_wmask_i = wm;
  endtask

  task automatic set_sw(input bit req, input bit wr, input int addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    bus.sw_req_i = req; bus.sw_write_i = wr;
    bus.sw_addr_i = AW'(addr); bus.sw_wdata_i = wd; bus.sw_wmask_i = wm;
  endtask

  // One clock: check the current low phase against the model, then advance the model.
  task automatic cycle();
    bit ex_hw, ex_sw, hold, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d, m;
    #1;
    hold  = m_locked && bus.hw_lock_i;
    ex_hw = 1'b0;
    ex_sw = 1'b0;
    if (rst_ni) begin
      if (hold) ex_hw = bus.hw_req_i;
      else if (bus.hw_req_i && bus.sw_req_i) begin
        if (m_wait >= LIM) ex_sw = 1'b1; else ex_hw = 1'b1;
      end else begin
        ex_hw = bus.hw_req_i;
        ex_sw = bus.sw_req_i;
      end
    end
    o_hw_gnt = bus.hw_gnt_o;   o_sw_gnt = bus.sw_gnt_o;
    o_hw_rv  = bus.hw_rvalid_o; o_sw_rv = bus.sw_rvalid_o;
    o_hw_rd  = bus.hw_rdata_o;  o_sw_rd = bus.sw_rdata_o;

    chk("hw_gnt", DW'(bus.hw_gnt_o), DW'(ex_hw));
    chk("sw_gnt", DW'(bus.sw_gnt_o), DW'(ex_sw));
    chk("mem_req", DW'(bus.mem_req_o), DW'(ex_hw | ex_sw));
    chk("locked", DW'(locked), DW'(rst_ni && m_locked));
    chk("hw_rvalid", DW'(bus.hw_rvalid_o), DW'(rst_ni && m_pend && !m_owner_sw));
    chk("sw_rvalid", DW'(bus.sw_rvalid_o), DW'(rst_ni && m_pend && m_owner_sw));
    chk("hw_rdata", bus.hw_rdata_o, (rst_ni && m_pend && !m_owner_sw) ? m_exp : '0);
    chk("sw_rdata", bus.sw_rdata_o, (rst_ni && m_pend && m_owner_sw) ? m_exp : '0);

    wr = ex_hw ? bus.hw_write_i : bus.sw_write_i;
    a  = ex_hw ? bus.hw_addr_i  : bus.sw_addr_i;
    d  = ex_hw ? bus.hw_wdata_i : bus.sw_wdata_i;
    m  = ex_hw ? bus.hw_wmask_i : bus.sw_wmask_i;
    if (ex_hw || ex_sw) begin
      chk("mem_addr", DW'(bus.mem_addr_o), DW'(a));
      chk("mem_write", DW'(bus.mem_write_o), DW'(wr));
      if (wr) begin
        chk("mem_wdata", bus.mem_wdata_o, d);
        chk("mem_wmask", bus.mem_wmask_o, m);
      end
    end else if (!rst_ni) begin
      chk("rst_mem_addr", DW'(bus.mem_addr_o), '0);
      chk("rst_mem_write", DW'(bus.mem_write_o), '0);
    end

    if (!rst_ni) begin
      m_wait = 0; m_locked = 1'b0; m_pend = 1'b0; m_owner_sw = 1'b0;
      preload_shadow();
    end else begin
      if (!bus.sw_req_i || ex_sw) m_wait = 0;
      else if (m_wait < LIM) m_wait++;
      m_locked   = hold || (ex_hw && bus.hw_lock_i);
      m_pend     = (ex_hw || ex_sw) && !wr;
      m_owner_sw = ex_sw;
      if (m_pend) m_exp = shadow[a];
      if ((ex_hw || ex_sw) && wr) shadow[a] = (shadow[a] & ~m) | (d & m);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    set_hw(0, 0, 0, 0, '0, '0);
    set_sw(0, 0, 0, '0, '0);
    m_wait = 0; m_locked = 0; m_pend = 0; m_owner_sw = 0; m_exp = '0;
    preload_shadow();
    @(negedge clk);
    cycle();
    cycle();
    rst_ni = 1'b1;

    // hw read of address 5
    set_hw(1, 0, 0, 5, '0, '0);
    cycle();
    chk("hw_read_gnt", DW'(o_hw_gnt), DW'(1'b1));
    set_hw(0, 0, 0, 0, '0, '0);
    cycle();
    chk("hw_read_data", o_hw_rd, 64'h0123_4567_89AB_CDEF);
    chk("hw_read_sw_rv", DW'(o_sw_rv), DW'(1'b0));

    // both requesting: four hw grants, then a forced sw grant, repeating
    set_hw(1, 0, 0, 1, '0, '0);
    set_sw(1, 0, 3, '0, '0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_seq", DW'(o_sw_gnt), DW'((i % 5) == 4));
    end
    set_hw(0, 0, 0, 0, '0, '0);
    set_sw(0, 0, 0, '0, '0);
    cycle();

    // locked RMW on address 2 while sw waits
    set_sw(1, 0, 2, '0, '0);
    set_hw(1, 1, 1, 2, 64'hDEAD_BEEF_0000_0001, '1);
    cycle();
    set_hw(1, 1, 0, 2, '0, '0);
    cycle();
    set_hw(1, 1, 1, 2, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_00FF);
    cycle();
    chk("lock_sw_held", DW'(o_sw_gnt), DW'(1'b0));
    set_hw(0, 1, 0, 0, '0, '0);
    cycle();
    cycle();
    set_hw(1, 0, 0, 2, '0, '0);
    cycle();
    chk("lock_release_sw", DW'(o_sw_gnt), DW'(1'b1));
    set_hw(0, 0, 0, 0, '0, '0);
    set_sw(0, 0, 0, '0, '0);
    cycle();
    chk("lock_rmw_data", o_sw_rd, 64'hDEAD_BEEF_0000_0002);

    // interleaved reads
    set_hw(1, 0, 0, 1, '0, '0);
    cycle();
    set_hw(0, 0, 0, 0, '0, '0);
    set_sw(1, 0, 3, '0, '0);
    cycle();
    chk("ilv_hw_data", o_hw_rd, 64'h1111_2222_3333_4444);
    set_sw(0, 0, 0, '0, '0);
    cycle();
    chk("ilv_sw_data", o_sw_rd, 64'h3333_CCCC_0000_FFFF);

    // reset the cycle after a granted sw read
    set_sw(1, 0, 3, '0, '0);
    cycle();
    set_sw(0, 0, 0, '0, '0);
    rst_ni = 1'b0;
    cycle();
    chk("rst_sw_rv", DW'(o_sw_rv), DW'(1'b0));
    rst_ni = 1'b1;
    set_sw(1, 0, 4, '0, '0);
    cycle();
    chk("post_rst_sw_gnt", DW'(o_sw_gnt), DW'(1'b1));

    // masked sw write then readback
    set_sw(1, 1, 7, 64'hAAAA_AAAA_5555_5555, 64'h0000_0000_FFFF_FFFF);
    cycle();
    set_sw(1, 0, 7, '0, '0);
    cycle();
    set_sw(0, 0, 0, '0, '0);
    cycle();
    chk("mask_readback", o_sw_rd, 64'h0000_0000_5555_5555);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_ni = ($urandom_range(0, 79) != 0);
      set_hw($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, {$urandom, $urandom});
      set_sw($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, {$urandom, $urandom});
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
